// File: rtl/divider_8bits_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : divider_8bits_seq
// Brief   : 16/8 unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
module divider_8bits_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_ALL_ONES = 8'hFF;
  localparam logic [2:0] C_LAST_STEP = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] divisor_q, divisor_d;
  logic [2:0] cnt_q, cnt_d;
  logic       div_zero_q, div_zero_d;
  logic       overflow_q, overflow_d;

  logic [8:0] shifted_rem;
  logic [8:0] trial;
  logic       trial_neg;

  // Since rem < divisor, {rem,bit} - divisor lies in [-255, 254], so the
  // 9-bit trial's MSB is an exact sign bit even when {rem,bit} >= 256.
  assign shifted_rem = {rem_q, shift_q[7]};
  assign trial       = shifted_rem - {1'b0, divisor_q};
  assign trial_neg   = trial[8];

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          divisor_d  = divisor;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          cnt_d      = 3'd0;
          if (divisor == 8'd0) begin
            state_d    = DONE;
            shift_d    = C_ALL_ONES;
            rem_d      = dividend[7:0];
            div_zero_d = 1'b1;
          end else if (dividend[15:8] >= divisor) begin
            state_d    = DONE;
            shift_d    = C_ALL_ONES;
            rem_d      = C_ALL_ONES;
            overflow_d = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = dividend[15:8];
            shift_d = dividend[7:0];
          end
        end
      end

      CALC: begin
        // Dividend bits leave the top of shift_q while quotient bits enter
        // at the bottom, so after eight steps it holds the full quotient.
        shift_d = {shift_q[6:0], ~trial_neg};
        rem_d   = trial_neg ? shifted_rem[7:0] : trial[7:0];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == C_LAST_STEP) begin
          state_d    = DONE;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= 8'd0;
      shift_q    <= 8'd0;
      divisor_q  <= 8'd0;
      cnt_q      <= 3'd0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = shift_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_8bits_seq.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for divider_8bits_seq: directed vector table, corner
// sequences and randomized operations against an arithmetic reference model.
module tb_divider_8bits_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_8bits_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;   // edges after the accept edge until out_valid is seen
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Reference: plain integer division plus the flag rules.
  task automatic ref_model(input logic [15:0] dd, input logic [7:0] dv,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic dz, output logic ov, output int lat);
    int unsigned n, d;
    n = dd;
    d = dv;
    dz = 1'b0;
    ov = 1'b0;
    if (d == 0) begin
      q = 8'hFF; r = dd[7:0]; dz = 1'b1; lat = 0;
    end else if (n / d > 255) begin
      q = 8'hFF; r = 8'hFF; ov = 1'b1; lat = 0;
    end else begin
      q = 8'(n / d); r = 8'(n % d); lat = 8;
    end
  endtask

  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input int elat,
                        input int hold, input string tag);
    int lat;
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = dd;
    divisor   = dv;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    in_valid  = 1'($urandom);
    dividend  = 16'($urandom);
    divisor   = 8'($urandom);
    out_ready = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      in_valid  = 1'($urandom);
      dividend  = 16'($urandom);
      divisor   = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check($sformatf("%s.latency", tag), 32'(lat), 32'(elat));
    if (!out_valid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check($sformatf("%s.quotient", tag), 32'(quotient), 32'(eq));
    check($sformatf("%s.remainder", tag), 32'(remainder), 32'(er));
    check($sformatf("%s.flags", tag), 32'({div_zero, overflow}), 32'({edz, eov}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s.hold%0d", tag, i),
            32'({out_valid, in_ready, quotient, remainder, div_zero, overflow}),
            32'({1'b1, 1'b0, eq, er, edz, eov}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s.release", tag), 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    logic [15:0] dd;
    logic [7:0]  dv, eq, er;
    logic        edz, eov;
    int          elat, mode, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = 16'd0; divisor = 8'd0;
    repeat (2) @(negedge clk);
    check("reset.outputs",
          32'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          32'({1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}));

    // Reset wins over an accept on the same edge.
    in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    check("reset.over_accept", 32'({in_ready, out_valid}), 32'b10);
    rst = 1'b0; in_valid = 1'b0;

    tbl[0] = '{16'h4E20, 8'd100, 8'd200, 8'd0,   1'b0, 1'b0, 8};
    tbl[1] = '{16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 8};
    tbl[2] = '{16'hFEFF, 8'hFF,  8'hFF,  8'hFE,  1'b0, 1'b0, 8};
    tbl[3] = '{16'h1234, 8'h12,  8'hFF,  8'hFF,  1'b0, 1'b1, 0};
    tbl[4] = '{16'h00AB, 8'd0,   8'hFF,  8'hAB,  1'b1, 1'b0, 0};
    tbl[5] = '{16'h0000, 8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 8};
    tbl[6] = '{16'h00FF, 8'd1,   8'hFF,  8'd0,   1'b0, 1'b0, 8};
    tbl[7] = '{16'h0100, 8'd2,   8'd128, 8'd0,   1'b0, 1'b0, 8};
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov,
             tbl[i].lat, $urandom_range(0, 3), $sformatf("vec%0d", i));
    end

    // Consumer stalls for 20 cycles.
    run_op(16'h4E20, 8'd100, 8'd200, 8'd0, 1'b0, 1'b0, 8, 20, "stall");

    // Reset during the 4th CALC cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midcalc.busy", 32'({in_ready, out_valid}), 32'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midcalc.outputs",
          32'({in_ready, out_valid, quotient, remainder, div_zero, overflow}),
          32'({1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midcalc.no_out_valid", 32'(seen), 32'd0);
    run_op(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 8, 1, "after_rst");

    for (int i = 0; i < 60; i++) begin
      dv   = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 3);
      if (mode == 0 || dv == 8'd0) dd = 16'($urandom);
      else dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
      ref_model(dd, dv, eq, er, edz, eov, elat);
      run_op(dd, dv, eq, er, edz, eov, elat, $urandom_range(0, 2),
             $sformatf("rnd%0d_%0h_%0h", i, dd, dv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
